// File: rtl/board_scan_ctrl.sv
// Tic-tac-toe board scanner: steps a nine-way cell mux, captures the board,
// then evaluates all eight lines for winner / draw / illegal-board results.
module board_scan_ctrl #(
  parameter int CELL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [8:0]        sel,
  input  logic [CELL_W-1:0] cell_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic              draw,
  output logic              invalid
);

  typedef enum logic [1:0] {IDLE, SCAN, EVAL, DONE} state_t;

  // Cell indices of the eight lines, packed {c, b, a} per 12-bit slot, line 0 in the LSBs.
  localparam logic [95:0] LINE_TBL = {
    4'd6, 4'd4, 4'd2,  4'd8, 4'd4, 4'd0,  4'd8, 4'd5, 4'd2,  4'd7, 4'd4, 4'd1,
    4'd6, 4'd3, 4'd0,  4'd8, 4'd7, 4'd6,  4'd5, 4'd4, 4'd3,  4'd2, 4'd1, 4'd0
  };

  state_t     state;
  logic [1:0] board [9];
  logic [1:0] cell_code;
  logic [7:0] x_line;
  logic [7:0] o_line;
  logic [8:0] cell_bad;
  logic [8:0] cell_full;
  logic       x_win;
  logic       o_win;
  logic       bad_board;

  // 2'b11 stands for every illegal cell value, not only 3.
  always_comb begin
    cell_code = 2'b11;
    if (cell_data == CELL_W'(0))
      cell_code = 2'b00;
    else if (cell_data == CELL_W'(1))
      cell_code = 2'b01;
    else if (cell_data == CELL_W'(2))
      cell_code = 2'b10;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      localparam logic [3:0] A = LINE_TBL[gi*12 +: 4];
      localparam logic [3:0] B = LINE_TBL[gi*12 + 4 +: 4];
      localparam logic [3:0] C = LINE_TBL[gi*12 + 8 +: 4];
      assign x_line[gi] = (board[A] == 2'b01) && (board[B] == 2'b01) && (board[C] == 2'b01);
      assign o_line[gi] = (board[A] == 2'b10) && (board[B] == 2'b10) && (board[C] == 2'b10);
    end
    for (gi = 0; gi < 9; gi++) begin : g_cell
      assign cell_bad[gi]  = (board[gi] == 2'b11);
      assign cell_full[gi] = (board[gi] != 2'b00);
    end
  endgenerate

  assign x_win     = |x_line;
  assign o_win     = |o_line;
  assign bad_board = (|cell_bad) || (x_win && o_win);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 9'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      winner  <= 2'b00;
      draw    <= 1'b0;
      invalid <= 1'b0;
      for (int i = 0; i < 9; i++) board[i] <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // The done cycle itself swallows start, giving one idle gap when start is held.
          if (start && !done) begin
            state <= SCAN;
            sel   <= 9'd0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          board[sel[3:0]] <= cell_code;
          if (sel == 9'd8) begin
            sel   <= 9'd0;
            state <= EVAL;
          end else begin
            sel <= sel + 9'd1;
          end
        end
        EVAL: begin
          if (bad_board) begin
            invalid <= 1'b1;
            winner  <= 2'b00;
            draw    <= 1'b0;
          end else begin
            invalid <= 1'b0;
            winner  <= x_win ? 2'b01 : (o_win ? 2'b10 : 2'b00);
            draw    <= !x_win && !o_win && (&cell_full);
          end
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
